// File: rtl/queen_stack_ctrl.sv
// queen_stack_ctrl: controller for an N-queens placement stack kept in an
// external synchronous single-port RAM.  Push takes one cycle after the
// request is sampled; pop takes two (address cycle, then capture cycle).
// Optional feature macro: QUEEN_STACK_ERR_EN adds a sticky err flag for
// refused requests (push while full, pop while empty) plus its clear input.
module queen_stack_ctrl #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 6,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [DW-1:0] push_data,
    output logic          ack,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef QUEEN_STACK_ERR_EN
    ,
    output logic          err,
    input  logic          err_clr
`endif
);

    typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_CAP} state_t;

    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        state, state_nxt;
    logic [AW:0]   sp;
    logic [DW-1:0] push_data_q;
    logic          flush_go, push_go, pop_go;

    // Request arbitration in IDLE, next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        flush_go  = 1'b0;
        push_go   = 1'b0;
        pop_go    = 1'b0;
        ack       = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                flush_go = flush;
                push_go  = !flush && push_req && !full;
                pop_go   = !flush && !push_go && pop_req && !empty;
                if (push_go)
                    state_nxt = PUSH;
                else if (pop_go)
                    state_nxt = POP_RD;
            end
            PUSH: begin
                ack       = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp[AW-1:0];
                state_nxt = IDLE;
            end
            POP_RD: begin
                mem_re    = 1'b1;
                // sp >= 1 here, so the low bits minus one is the top entry.
                mem_addr  = sp[AW-1:0] - ADDR_ONE;
                state_nxt = POP_CAP;
            end
            POP_CAP: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign empty     = (sp == '0);
    assign full      = (sp == SP_FULL);
    assign count     = sp;
    assign busy      = (state != IDLE);
    assign mem_wdata = push_data_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Stack pointer: cleared by flush, moved only when an operation completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sp <= '0;
        else if (flush_go)
            sp <= '0;
        else if (state == PUSH)
            sp <= sp + SP_ONE;
        else if (state == POP_CAP)
            sp <= sp - SP_ONE;
    end

    // Push data is captured when the push is accepted and held through PUSH.
    always_ff @(posedge clk) begin
        if (push_go)
            push_data_q <= push_data;
    end

    // Popped entry: invalidated by any accepted operation, refreshed on capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else if (flush_go || push_go || pop_go) begin
            pop_valid <= 1'b0;
        end else if (state == POP_CAP) begin
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
        end
    end

`ifdef QUEEN_STACK_ERR_EN
    logic refused;

    // A pop that loses to an accepted push is still pending, not refused.
    assign refused = (state == IDLE) && !flush &&
                     ((push_req && full) || (pop_req && empty && !push_go));

    // Sticky error flag; an explicit clear beats a simultaneous set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (err_clr)
            err <= 1'b0;
        else if (refused)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_queen_stack_ctrl.sv
// Self-checking bench for queen_stack_ctrl: a queue-based stack model
// predicts every cycle's outputs; directed scenarios are followed by
// randomized traffic.  Honours QUEEN_STACK_ERR_EN when defined.
module tb_queen_stack_ctrl;
    localparam int DEPTH = 8;
    localparam int DW    = 6;
    localparam int AW    = 3;
`ifdef QUEEN_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk, reset, flush, push_req, pop_req;
    logic [DW-1:0] push_data, pop_data, mem_wdata, mem_rdata;
    logic          ack, pop_valid, empty, full, busy, mem_we, mem_re;
    logic [AW:0]   count;
    logic [AW-1:0] mem_addr;
`ifdef QUEEN_STACK_ERR_EN
    logic          err, err_clr;
`else
    logic          err_clr;
`endif

    queen_stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .push_req(push_req),
        .pop_req(pop_req), .push_data(push_data), .ack(ack),
        .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty),
        .full(full), .count(count), .busy(busy), .mem_we(mem_we),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef QUEEN_STACK_ERR_EN
        , .err(err), .err_clr(err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM behind the controller.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the stack contents plus the visible flags.
    logic [DW-1:0] q[$];
    bit            m_pv, m_err;
    logic [DW-1:0] m_pd;
    bit            e_busy, e_ack, e_we, e_re;
    int            e_addr;
    logic [DW-1:0] e_wdata;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        e_busy = 0; e_ack = 0; e_we = 0; e_re = 0;
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full",  32'(full),  32'(q.size() == DEPTH));
        check("busy",  32'(busy),  32'(e_busy));
        check("ack",   32'(ack),   32'(e_ack));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_re", 32'(mem_re), 32'(e_re));
        check("pop_valid", 32'(pop_valid), 32'(m_pv));
        if (e_we || e_re) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        if (m_pv) check("pop_data", 32'(pop_data), 32'(m_pd));
`ifdef QUEEN_STACK_ERR_EN
        check("err", 32'(err), 32'(m_err));
`endif
        @(posedge clk);
        #1;
    endtask

    // Present one set of requests; requesters hold until ack or refusal.
    task automatic op(input bit p, input bit o, input bit f, input logic [DW-1:0] d, input bit clr);
        bit push_ok, pop_ok, refused;
        push_req = p; pop_req = o; flush = f; push_data = d; err_clr = clr;
        forever begin
            set_idle();
            tick();
            err_clr = 0;
            if (f) begin
                q.delete(); m_pv = 0; flush = 0; f = 0;
                if (clr) m_err = 0;
            end else begin
                push_ok = p && (q.size() < DEPTH);
                pop_ok  = o && !push_ok && (q.size() > 0);
                refused = (p && q.size() == DEPTH) || (o && q.size() == 0 && !push_ok);
                if (clr) m_err = 0;
                else if (refused && ERR_EN) m_err = 1;
                if (p && !push_ok) begin p = 0; push_req = 0; end
                if (o && !pop_ok && !push_ok) begin o = 0; pop_req = 0; end
                if (push_ok) begin
                    m_pv = 0;
                    e_busy = 1; e_ack = 1; e_we = 1; e_addr = q.size(); e_wdata = d;
                    push_req = 0; p = 0;
                    tick();
                    q.push_back(d);
                end else if (pop_ok) begin
                    m_pv = 0;
                    e_busy = 1; e_re = 1; e_addr = q.size() - 1;
                    tick();
                    set_idle(); e_busy = 1; e_ack = 1;
                    pop_req = 0; o = 0;
                    tick();
                    m_pd = q.pop_back(); m_pv = 1;
                end
            end
            clr = 0;
            if (!p && !o && !f) break;
        end
    endtask

    initial begin
        reset = 1; flush = 0; push_req = 0; pop_req = 0; push_data = '0; err_clr = 0;
        m_pv = 0; m_err = 0; m_pd = '0;
        set_idle();
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_we_re", 32'({mem_we, mem_re}), 0);
        check("rst_pop_valid", 32'(pop_valid), 0);
        check("rst_pop_data", 32'(pop_data), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // Three pushes then two pops.
        op(1, 0, 0, 6'h05, 0);
        op(1, 0, 0, 6'h13, 0);
        op(1, 0, 0, 6'h2A, 0);
        check("lit_count3", 32'(count), 3);
        op(0, 1, 0, '0, 0);
        check("lit_pop1", 32'(pop_data), 32'h2A);
        op(0, 1, 0, '0, 0);
        check("lit_pop2", 32'(pop_data), 32'h13);
        check("lit_count1", 32'(count), 1);

        // Fill to DEPTH, then a refused push.
        for (int i = 0; i < DEPTH - 1; i++) op(1, 0, 0, 6'(i + 8), 0);
        check("lit_full", 32'(full), 1);
        op(1, 0, 0, 6'h3F, 0);
        check("lit_count8", 32'(count), 8);
`ifdef QUEEN_STACK_ERR_EN
        check("lit_err_set", 32'(err), 1);
        op(0, 0, 0, '0, 1);
        check("lit_err_clr", 32'(err), 0);
`endif

        // Pop while empty.
        op(0, 0, 1, '0, 0);
        op(0, 1, 0, '0, 0);
        check("lit_empty", 32'(empty), 1);
`ifdef QUEEN_STACK_ERR_EN
        check("lit_err_empty", 32'(err), 1);
        op(0, 0, 0, '0, 1);
`endif

        // Simultaneous push and pop: push wins, pop returns the pushed entry.
        op(1, 0, 0, 6'h01, 0);
        op(1, 0, 0, 6'h02, 0);
        op(1, 1, 0, 6'h31, 0);
        check("lit_both_data", 32'(pop_data), 32'h31);
        check("lit_both_count", 32'(count), 2);

        // Reset in the middle of a pop with four entries.
        op(1, 0, 0, 6'h03, 0);
        op(1, 0, 0, 6'h04, 0);
        pop_req = 1;
        set_idle();
        tick();
        check("lit_in_pop_rd", 32'(mem_re), 1);
        #2 reset = 1;
        #1;
        check("lit_rst_ack", 32'(ack), 0);
        check("lit_rst_re", 32'(mem_re), 0);
        check("lit_rst_busy", 32'(busy), 0);
        check("lit_rst_count", 32'(count), 0);
        check("lit_rst_empty", 32'(empty), 1);
        check("lit_rst_pv", 32'(pop_valid), 0);
        pop_req = 0;
        q.delete(); m_pv = 0; m_pd = '0; m_err = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // Flush with five entries.
        for (int i = 0; i < 5; i++) op(1, 0, 0, 6'(i + 40), 0);
        op(0, 0, 1, '0, 0);
        check("lit_flush_count", 32'(count), 0);

        // Randomized traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 500; i++) begin
            int r;
            bit clr;
            logic [DW-1:0] d;
            r   = $urandom_range(0, 99);
            clr = ($urandom_range(0, 9) == 0);
            d   = DW'($urandom);
            if ((i / 60) % 2 == 1) r = 99 - r;
            if (r < 50)      op(1, 0, 0, d, clr);
            else if (r < 60) op(1, 1, 0, d, clr);
            else if (r < 88) op(0, 1, 0, d, clr);
            else if (r < 92) op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, d, clr);
            else             op(0, 0, 0, d, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
